alu_arbiter: RTL

Two-port arbiter and sequencer for the shared 32-bit ALU datapath. Two requesters, such as an instruction-issue port and a debug/DMA port, each present an operation with a valid/ready handshake. The block grants one request at a time, captures its operands, runs the ALU for one registered cycle, and returns the result only to the granted requester. It owns the only path into the ALU operation slice (AND/OR/XOR/ADD/SUB/NOR/SLT/PASS).

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a registered 32-bit ALU slice.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic [2:0]       req_op0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid0,
  input  logic             rsp_ready0,
  output logic             rsp_valid1,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             busy
);

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpOr   = 3'b001;
  localparam logic [2:0] OpXor  = 3'b010;
  localparam logic [2:0] OpAdd  = 3'b011;
  localparam logic [2:0] OpSub  = 3'b100;
  localparam logic [2:0] OpNor  = 3'b101;
  localparam logic [2:0] OpSlt  = 3'b110;
  localparam logic [2:0] OpPass = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic             owner_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic             rsp_carry_q;
  logic             rsp_valid0_q;
  logic             rsp_valid1_q;
  logic             busy_q;

  logic             grant0;
  logic             grant1;
  logic             idle;
  logic             rsp_ready_own;

  logic             is_sub;
  logic [WIDTH-1:0] b_add;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = req_valid0;
  assign grant1 = req_valid1 & ~req_valid0;
`else
  logic rr_ptr_q;
  assign grant0 = req_valid0 & (~req_valid1 | ~rr_ptr_q);
  assign grant1 = req_valid1 & (~req_valid0 | rr_ptr_q);
`endif

  // Gate with rst_n so no handshake is offered while reset is held.
  assign idle          = rst_n & (state_q == StIdle);
  assign req_ready0    = idle & grant0;
  assign req_ready1    = idle & grant1;
  assign rsp_ready_own = owner_q ? rsp_ready1 : rsp_ready0;

  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_carry  = rsp_carry_q;
  assign busy       = busy_q;

  // SUB shares the adder as A + ~B + 1 so carry-out is the NOT-borrow flag.
  always_comb begin
    is_sub    = (op_q == OpSub);
    b_add     = is_sub ? ~b_q : b_q;
    sum       = {1'b0, a_q} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (op_q)
      OpAnd:  alu_res = a_q & b_q;
      OpOr:   alu_res = a_q | b_q;
      OpXor:  alu_res = a_q ^ b_q;
      OpAdd: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OpSub: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OpNor:  alu_res = ~(a_q | b_q);
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OpPass: alu_res = a_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      busy_q       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_ready0 || req_ready1) begin
            owner_q <= req_ready1;
            op_q    <= req_ready1 ? req_op1 : req_op0;
            a_q     <= req_ready1 ? req_a1  : req_a0;
            b_q     <= req_ready1 ? req_b1  : req_b0;
            busy_q  <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_data_q   <= alu_res;
          rsp_zero_q   <= (alu_res == '0);
          rsp_carry_q  <= alu_carry;
          rsp_valid0_q <= ~owner_q;
          rsp_valid1_q <= owner_q;
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_ready_own) begin
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= ~owner_q;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
